control_sequencer: RTL

Hardwired Moore control unit that drives the datapath's strobe inputs, replacing the hand-sequenced control currently written into benches. It runs the three-cycle fetch (T0–T2), then decodes IR_Data and issues execute steps for register ALU, unary, mul/div, nop and halt instructions. One state step per clk; all outputs decode from the state register plus IR_Data fields.

---
 rtl/control_sequencer_if.sv | 40 ++++
 rtl/control_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Strobe bundle between the hardwired control sequencer and the datapath.
// The sequencer reads run and IR_Data, and drives every strobe and status line.
interface control_sequencer_if;
    logic        run;
    logic [31:0] IR_Data;
    logic        PC_out;
    logic        MAR_in;
    logic        IncPC;
    logic        Z_in;
    logic        Zlow_out;
    logic        Zhigh_out;
    logic        PC_in;
    logic        Read;
    logic        MDR_in;
    logic        MDR_out;
    logic        IR_in;
    logic        Y_in;
    logic        HI_in;
    logic        LO_in;
    logic [15:0] R_in;
    logic [15:0] R_out;
    logic [4:0]  alu_instruction;
    logic        done;
    logic        halted;
    logic        fault;

    modport master (
        input  run, IR_Data,
        output PC_out, MAR_in, IncPC, Z_in, Zlow_out, Zhigh_out, PC_in, Read,
               MDR_in, MDR_out, IR_in, Y_in, HI_in, LO_in, R_in, R_out,
               alu_instruction, done, halted, fault
    );

    modport slave (
        output run, IR_Data,
        input  PC_out, MAR_in, IncPC, Z_in, Zlow_out, Zhigh_out, PC_in, Read,
               MDR_in, MDR_out, IR_in, Y_in, HI_in, LO_in, R_in, R_out,
               alu_instruction, done, halted, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: three-cycle fetch, then decode-driven execute
// steps for register ALU, unary, mul/div, nop and halt instructions.
module control_sequencer #(
    parameter logic [4:0] OP_MUL  = 5'b01111,
    parameter logic [4:0] OP_DIV  = 5'b10000,
    parameter logic [4:0] OP_NEG  = 5'b10001,
    parameter logic [4:0] OP_NOT  = 5'b10010,
    parameter logic [4:0] OP_NOP  = 5'b11010,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic                       clk,
    input  logic                       clr,
    control_sequencer_if.master        bus
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, FAULT
    } state_t;

    state_t state;
    state_t next_state;

    logic [4:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [15:0] ra_hot;
    logic [15:0] rb_hot;
    logic [15:0] rc_hot;
    logic        is_alu3;
    logic        is_muldiv;
    logic        is_unary;
    logic        is_nop;
    logic        is_halt;
    logic        unused_ir;
    state_t      after_done;

    assign op        = bus.IR_Data[31:27];
    assign ra        = bus.IR_Data[26:23];
    assign rb        = bus.IR_Data[22:19];
    assign rc        = bus.IR_Data[18:15];
    assign unused_ir = ^bus.IR_Data[14:0];

    assign ra_hot = 16'b1 << ra;
    assign rb_hot = 16'b1 << rb;
    assign rc_hot = 16'b1 << rc;

    assign is_alu3   = (op <= 5'b01110);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_unary  = (op == OP_NEG) || (op == OP_NOT);
    assign is_nop    = (op == OP_NOP);
    assign is_halt   = (op == OP_HALT);

    // Once the last step of an instruction retires, run alone decides whether to fetch again.
    assign after_done = bus.run ? T0 : IDLE;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state          = state;
        bus.PC_out          = 1'b0;
        bus.MAR_in          = 1'b0;
        bus.IncPC           = 1'b0;
        bus.Z_in            = 1'b0;
        bus.Zlow_out        = 1'b0;
        bus.Zhigh_out       = 1'b0;
        bus.PC_in           = 1'b0;
        bus.Read            = 1'b0;
        bus.MDR_in          = 1'b0;
        bus.MDR_out         = 1'b0;
        bus.IR_in           = 1'b0;
        bus.Y_in            = 1'b0;
        bus.HI_in           = 1'b0;
        bus.LO_in           = 1'b0;
        bus.R_in            = 16'h0000;
        bus.R_out           = 16'h0000;
        bus.alu_instruction = 5'b00000;
        bus.done            = 1'b0;
        bus.halted          = 1'b0;
        bus.fault           = 1'b0;

        case (state)
            IDLE: begin
                if (bus.run) next_state = T0;
            end
            // Fetch steps never look at IR_Data, which is stale until T3.
            T0: begin
                bus.PC_out = 1'b1;
                bus.MAR_in = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Z_in   = 1'b1;
                next_state = T1;
            end
            T1: begin
                bus.Zlow_out = 1'b1;
                bus.PC_in    = 1'b1;
                bus.Read     = 1'b1;
                bus.MDR_in   = 1'b1;
                next_state   = T2;
            end
            T2: begin
                bus.MDR_out = 1'b1;
                bus.IR_in   = 1'b1;
                next_state  = T3;
            end
            T3: begin
                if (is_alu3 || is_muldiv) begin
                    bus.R_out  = rb_hot;
                    bus.Y_in   = 1'b1;
                    next_state = T4;
                end else if (is_unary) begin
                    bus.R_out           = rb_hot;
                    bus.alu_instruction = op;
                    bus.Z_in            = 1'b1;
                    next_state          = T4;
                end else if (is_nop) begin
                    bus.done   = 1'b1;
                    next_state = after_done;
                end else if (is_halt) begin
                    next_state = HALT;
                end else begin
                    next_state = FAULT;
                end
            end
            T4: begin
                if (is_alu3 || is_muldiv) begin
                    bus.R_out           = rc_hot;
                    bus.alu_instruction = op;
                    bus.Z_in            = 1'b1;
                    next_state          = T5;
                end else if (is_unary) begin
                    bus.Zlow_out = 1'b1;
                    bus.R_in     = ra_hot;
                    bus.done     = 1'b1;
                    next_state   = after_done;
                end else begin
                    next_state = FAULT;
                end
            end
            T5: begin
                if (is_alu3) begin
                    bus.Zlow_out = 1'b1;
                    bus.R_in     = ra_hot;
                    bus.done     = 1'b1;
                    next_state   = after_done;
                end else if (is_muldiv) begin
                    bus.Zlow_out = 1'b1;
                    bus.LO_in    = 1'b1;
                    next_state   = T6;
                end else begin
                    next_state = FAULT;
                end
            end
            T6: begin
                if (is_muldiv) begin
                    bus.Zhigh_out = 1'b1;
                    bus.HI_in     = 1'b1;
                    bus.done      = 1'b1;
                    next_state    = after_done;
                end else begin
                    next_state = FAULT;
                end
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            FAULT: begin
                bus.fault = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
